// File: rtl/dcache_req_port_driver.sv
// D$ request-port driver: cmd/rsp stream to two-phase index/tag cache protocol.
// Optional kill input enabled by defining DCACHE_DRV_KILL_EN.

package dcache_drv_pkg;
  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_req_port_driver
  import dcache_drv_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter bit          IsStorePort   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef DCACHE_DRV_KILL_EN
  input  logic              cmd_kill_i,
`endif
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [PLEN-1:0]   cmd_addr_i,
  input  logic [XLEN-1:0]   cmd_wdata_i,
  input  logic [XLEN/8-1:0] cmd_be_i,
  input  logic [1:0]        cmd_size_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_we_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              timeout_o,
  output logic              busy_o,
  output dcache_req_i_t     dcache_req_o,
  input  dcache_req_o_t     dcache_rsp_i
);

  localparam int IdxW = DCACHE_INDEX_WIDTH;
  localparam int TagW = DCACHE_TAG_WIDTH;
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, TAG, WAIT, RSP
  } state_e;

  state_e          state;
  logic [PLEN-1:0] addr_q;
  logic [CntW-1:0] cnt;
  logic            cmd_we;
  logic            kill;
  logic            tmo_hit;

  assign cmd_we  = IsStorePort ? 1'b1 : cmd_we_i;
  assign tmo_hit = (cnt == CntLast);

`ifdef DCACHE_DRV_KILL_EN
  assign kill = cmd_kill_i;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_we_o     <= 1'b0;
      rsp_rdata_o  <= '0;
      timeout_o    <= 1'b0;
      busy_o       <= 1'b0;
      dcache_req_o <= '0;
    end else begin
      if (state inside {REQ, TAG, WAIT} && cnt != CntMax)
        cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          dcache_req_o <= '0;
          if (cmd_valid_i) begin
            state       <= REQ;
            cnt         <= '0;
            addr_q      <= cmd_addr_i;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            dcache_req_o.data_req      <= 1'b1;
            dcache_req_o.data_we       <= cmd_we;
            dcache_req_o.data_be       <= cmd_be_i;
            dcache_req_o.data_size     <= cmd_size_i;
            dcache_req_o.data_wdata    <= cmd_wdata_i;
            dcache_req_o.address_index <= cmd_addr_i[IdxW-1:0];
            // stores present the full address in the grant cycle
            dcache_req_o.address_tag <= cmd_we ?
              cmd_addr_i[TagW+IdxW-1:IdxW] : '0;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state        <= IDLE;
            timeout_o    <= 1'b1;
            cmd_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            dcache_req_o <= '0;
          end else if (dcache_rsp_i.data_gnt) begin
            dcache_req_o <= '0;
            if (dcache_req_o.data_we) begin
              state       <= RSP;
              rsp_valid_o <= 1'b1;
              rsp_we_o    <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state <= TAG;
              dcache_req_o.tag_valid   <= 1'b1;
              dcache_req_o.address_tag <=
                addr_q[TagW+IdxW-1:IdxW];
            end
          end else if (kill) begin
            state        <= IDLE;
            cmd_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            dcache_req_o <= '0;
          end
        end
        TAG, WAIT: begin
          dcache_req_o <= '0;
          if (tmo_hit) begin
            state       <= IDLE;
            timeout_o   <= 1'b1;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (kill) begin
            // one-cycle kill pulse goes out while already back in IDLE
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            dcache_req_o.kill_req <= 1'b1;
          end else if (dcache_rsp_i.data_rvalid) begin
            state       <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= 1'b0;
            rsp_rdata_o <= dcache_rsp_i.data_rdata;
          end else begin
            state <= WAIT;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_we_o    <= 1'b0;
            rsp_rdata_o <= '0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cmd_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          dcache_req_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req_port_driver.sv
// Directed bench for dcache_req_port_driver with a response scoreboard.
// Kill scenario runs only when DCACHE_DRV_KILL_EN is defined.

module tb_dcache_req_port_driver;
  import dcache_drv_pkg::*;

  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [PLEN-1:0]   cmd_addr = '0;
  logic [XLEN-1:0]   cmd_wdata = '0;
  logic [XLEN/8-1:0] cmd_be = '0;
  logic [1:0]        cmd_size = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_we;
  logic [XLEN-1:0]   rsp_rdata;
  logic              timeout;
  logic              busy;
  dcache_req_i_t     dreq;
  dcache_req_o_t     drsp = '0;
`ifdef DCACHE_DRV_KILL_EN
  logic              cmd_kill = 1'b0;
`endif

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  dcache_req_port_driver #(
    .TimeoutCycles(TO),
    .IsStorePort(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef DCACHE_DRV_KILL_EN
    .cmd_kill_i(cmd_kill),
`endif
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .cmd_be_i(cmd_be),
    .cmd_size_i(cmd_size),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata),
    .timeout_o(timeout),
    .busy_o(busy),
    .dcache_req_o(dreq),
    .dcache_rsp_i(drsp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [191:0] obs,
                     input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we,
                       input logic [PLEN-1:0] a,
                       input logic [XLEN-1:0] wd,
                       input logic [7:0] be,
                       input logic [1:0] sz,
                       input bit push,
                       input logic [XLEN-1:0] rd);
    exp_t e;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_be    = be;
    cmd_size  = sz;
    cmd_valid = 1'b1;
    e.we   = we;
    e.data = we ? '0 : rd;
    if (push) sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(input string tag);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_sb"}, 192'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_we"}, rsp_we, e.we);
      chk({tag, "_rdata"}, rsp_rdata, e.data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 0);
    chk({tag, "_idle"}, cmd_ready, 1);
  endtask

  task automatic do_load(input logic [PLEN-1:0] a,
                         input logic [XLEN-1:0] d,
                         input string tag);
    drsp.data_gnt = 1'b1;
    issue(1'b0, a, '0, 8'hff, 2'd3, 1'b1, d);
    tick();
    drsp.data_gnt = 1'b0;
    tick();
    drsp.data_rvalid = 1'b1;
    drsp.data_rdata  = d;
    tick();
    drsp.data_rvalid = 1'b0;
    pop_rsp(tag);
  endtask

  initial begin
    dcache_req_i_t e;

    // reset values
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", dreq, 0);
    rst_n = 1'b1;
    tick();

    // load, immediate grant
    drsp.data_gnt = 1'b1;
    issue(1'b0, 56'h8000_0040, '0, 8'hff, 2'd3,
          1'b1, 64'hDEAD_BEEF_0000_1234);
    chk("ld_req", dreq.data_req, 1);
    chk("ld_index", dreq.address_index, 12'h040);
    chk("ld_busy", busy, 1);
    chk("ld_cmd_ready", cmd_ready, 0);
    tick();
    drsp.data_gnt = 1'b0;
    chk("ld_tag_req", dreq.data_req, 0);
    chk("ld_tag_valid", dreq.tag_valid, 1);
    chk("ld_tag", dreq.address_tag, 44'h80000);
    tick();
    chk("ld_tag_1cyc", dreq.tag_valid, 0);
    drsp.data_rvalid = 1'b1;
    drsp.data_rdata  = 64'hDEAD_BEEF_0000_1234;
    tick();
    drsp.data_rvalid = 1'b0;
    chk("ld_lat4", rsp_valid, 1);
    pop_rsp("ld");

    // store, grant after 5 cycles
    e = '0;
    e.address_index = 12'h100;
    e.address_tag   = 44'h80000;
    e.data_wdata    = 64'h55;
    e.data_req      = 1'b1;
    e.data_we       = 1'b1;
    e.data_be       = 8'h01;
    e.data_size     = 2'd0;
    issue(1'b1, 56'h8000_0100, 64'h55, 8'h01, 2'd0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      chk("st_req_stable", dreq, e);
      if (i == 5) drsp.data_gnt = 1'b1;
      tick();
    end
    drsp.data_gnt = 1'b0;
    chk("st_lat", rsp_valid, 1);
    chk("st_req_clr", dreq, 0);
    pop_rsp("st");

    // response backpressure, rvalid in the tag cycle
    drsp.data_gnt = 1'b1;
    issue(1'b0, 56'h8000_0208, '0, 8'hff, 2'd3,
          1'b1, 64'h0123_4567_89AB_CDEF);
    tick();
    drsp.data_gnt    = 1'b0;
    drsp.data_rvalid = 1'b1;
    drsp.data_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    drsp.data_rvalid = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 56'h8000_0300;
    cmd_wdata = 64'hAA;
    cmd_be    = 8'hff;
    cmd_size  = 2'd3;
    sb.push_back('{we: 1'b1, data: '0});
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    pop_rsp("bp");
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    chk("bp_next_req", dreq.data_req, 1);
    chk("bp_next_we", dreq.data_we, 1);
    drsp.data_gnt = 1'b1;
    tick();
    drsp.data_gnt = 1'b0;
    pop_rsp("bp_st");

    // timeout with grant withheld
    issue(1'b0, 56'h8000_0400, '0, 8'hff, 2'd3, 1'b0, '0);
    for (int i = 1; i <= TO; i++) begin
      chk("to_pending", timeout, 0);
      chk("to_busy", busy, 1);
      tick();
    end
    chk("to_flag", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_cmd_ready", cmd_ready, 1);
    chk("to_req_clr", dreq, 0);
    drsp.data_rvalid = 1'b1;
    drsp.data_rdata  = 64'hBAD;
    tick();
    drsp.data_rvalid = 1'b0;
    tick();
    chk("to_late_drop", rsp_valid, 0);
    chk("to_sticky", timeout, 1);
    do_load(56'h8000_0480, 64'h1111_2222_3333_4444, "to_ld");
    chk("to_sticky2", timeout, 1);

    // reset in WAIT
    drsp.data_gnt = 1'b1;
    issue(1'b0, 56'h8000_0500, '0, 8'hff, 2'd3, 1'b1, 64'h77);
    tick();
    drsp.data_gnt = 1'b0;
    tick();
    chk("rw_busy", busy, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rw_async", busy, 0);
    tick();
    rst_n = 1'b1;
    drsp.data_rvalid = 1'b1;
    drsp.data_rdata  = 64'h77;
    tick();
    drsp.data_rvalid = 1'b0;
    tick();
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_cmd_ready", cmd_ready, 1);
    chk("rw_busy_clr", busy, 0);
    chk("rw_timeout", timeout, 0);
    chk("rw_rdata", rsp_rdata, 0);
    chk("rw_req", dreq, 0);
    do_load(56'h8000_0540, 64'hCAFE_F00D_0000_0001, "rw_ld");

`ifdef DCACHE_DRV_KILL_EN
    // kill during the tag cycle
    drsp.data_gnt = 1'b1;
    issue(1'b0, 56'h8000_0600, '0, 8'hff, 2'd3, 1'b0, '0);
    tick();
    drsp.data_gnt = 1'b0;
    cmd_kill = 1'b1;
    tick();
    cmd_kill = 1'b0;
    chk("kl_kill", dreq.kill_req, 1);
    chk("kl_tag_valid", dreq.tag_valid, 0);
    chk("kl_req", dreq.data_req, 0);
    chk("kl_idle", cmd_ready, 1);
    tick();
    chk("kl_kill_1cyc", dreq.kill_req, 0);
    chk("kl_no_rsp", rsp_valid, 0);
    do_load(56'h8000_0640, 64'h4242_4242_4242_4242, "kl_ld");
`endif

    chk("sb_empty", 192'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_req_port_driver.md
# dcache_req_port_driver

Upstream request driver for one D$ request port of the std cache subsystem in the cache-only unit-test top. It converts a simple command/response valid-ready stream, issued by the bench or a traffic generator, into the two-phase `dcache_req_i_t`/`dcache_req_o_t` protocol: index and grant, then tag, then rvalid. It returns load data, or a store completion, on a one-deep response register. It also watches each transaction for a hung cache with a timeout counter. One instance sits on each of ports 0..2 of the subsystem's `dcache_req_ports_i/o`.

## Interface
- `TimeoutCycles`, default 1024 — cycles allowed from `data_req` assertion to completion before the timeout error.
- `IsStorePort`, default 0 — when 1, every command is forced to a store (port 2 usage).
- `clk_i` input 1 — clock.
- `rst_ni` input 1 — asynchronous active-low reset.
- `cmd_valid_i` input 1 — command valid.
- `cmd_ready_o` output 1 — command accepted when high together with `cmd_valid_i`.
- `cmd_we_i` input 1 — 1 = store, 0 = load.
- `cmd_addr_i` input `riscv::PLEN` — physical byte address.
- `cmd_wdata_i` input `riscv::XLEN` — store data.
- `cmd_be_i` input `riscv::XLEN/8` — byte enables.
- `cmd_size_i` input 2 — access size (0 = byte … 3 = dword).
- `rsp_valid_o` output 1 — response valid.
- `rsp_ready_i` input 1 — response consumed.
- `rsp_we_o` output 1 — response belongs to a store.
- `rsp_rdata_o` output `riscv::XLEN` — load data; 0 for stores.
- `timeout_o` output 1 — sticky error flag, cleared only by reset.
- `busy_o` output 1 — FSM not in IDLE.
- `dcache_req_o` output `dcache_req_i_t` — request to the cache port.
- `dcache_rsp_i` input `dcache_req_o_t` — response from the cache port.

## Operation
- States: IDLE, REQ, TAG, WAIT, RSP.
- **IDLE:** `cmd_ready_o` = 1. On handshake, latch the command and go to REQ.
- **REQ:**
  - Drive `data_req` = 1.
  - `address_index` = `addr[DCACHE_INDEX_WIDTH-1:0]`.
  - `data_we`, `data_be`, `data_size`, `data_wdata` from the latched command.
  - For stores, `address_tag` is also driven here.
  - Hold all fields stable until `data_gnt`.
- **On `data_gnt`:**
  - Load → TAG.
  - Store → RSP with `rsp_we_o` = 1. The store is complete at grant.
- **TAG (exactly one cycle):**
  - `data_req` = 0, `tag_valid` = 1.
  - `address_tag` = `addr[DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:DCACHE_INDEX_WIDTH]`.
  - Then go to WAIT.
  - If `data_rvalid` arrives in this cycle, capture the data and go straight to RSP.
- **WAIT:** on `data_rvalid`, capture `data_rdata` and go to RSP.
- **RSP:** `rsp_valid_o` = 1 until `rsp_ready_i`, then go to IDLE. There is no back-to-back bypass, so the next command is accepted in IDLE.
- **Timeout:**
  - The counter is cleared on entry to REQ and increments every cycle in REQ, TAG and WAIT.
  - Reaching `TimeoutCycles` sets `timeout_o` and forces the FSM to IDLE.
  - Any late `data_rvalid` is then dropped.
  - The counter saturates and does not wrap.
- When `IsStorePort` = 1, `cmd_we_i` is ignored and treated as 1.
- Unused `dcache_req_o` fields are driven to 0 in every state.

## Timing
- Reset values:
  - `cmd_ready_o` = 1.
  - `rsp_valid_o`, `rsp_we_o`, `timeout_o`, `busy_o` = 0.
  - `rsp_rdata_o` = 0.
  - `dcache_req_o` = '0.
  - FSM = IDLE, counter = 0.
- Reset mid-transaction aborts immediately. No response is emitted and a following rvalid is ignored.
- Best-case load: command handshake at cycle 0, `data_req` at 1, grant at 1, tag at 2, rvalid at 3, `rsp_valid_o` at 4.
- Best-case store: handshake at 0, req and grant at 1, `rsp_valid_o` at 2.
- All outputs are registered from FSM state.

## Configuration
- `DCACHE_DRV_KILL_EN`:
  - **Defined:** adds an input port `cmd_kill_i` (1 bit).
    - Asserted in TAG: drive `kill_req` = 1 with `tag_valid` = 0, then return to IDLE with no response.
    - Asserted in WAIT: drive `kill_req` for one cycle and return to IDLE; the eventual rvalid is discarded.
    - Asserted in REQ before grant: drop `data_req` and return to IDLE.
  - **Not defined:** the port is absent and `kill_req` is tied to 0.

## Test plan
- **Load, immediate grant:** addr 0x8000_0040, cache returns 0xDEAD_BEEF_0000_1234 → `rsp_rdata_o` matches; `rsp_valid_o` 4 cycles after handshake; `tag_valid` high for exactly one cycle.
- **Store, grant delayed 5 cycles:** addr 0x8000_0100, data 0x55, be 0x01, size 0 → request fields stable for all 6 req cycles; `rsp_we_o` = 1; `rsp_rdata_o` = 0.
- **Response backpressure:** `rsp_ready_i` low for 10 cycles → `rsp_valid_o` and data held; `cmd_ready_o` = 0 throughout; next command accepted 1 cycle after release.
- **Timeout:** `TimeoutCycles` = 16, grant never given → `timeout_o` rises on cycle 16 of REQ and stays high; FSM returns to IDLE.
- **Reset in WAIT:** `rst_ni` low for 1 cycle, then rvalid arrives → no `rsp_valid_o`; all outputs at reset values.
- **`DCACHE_DRV_KILL_EN` defined:** `cmd_kill_i` asserted in TAG → `kill_req` = 1 for one cycle; no response; next load completes normally.
